// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES linear-layer engine.
package aes_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned KIDX_W = 4;
  localparam logic [7:0]  AES_POLY = 8'h1B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ARK,
    S_SHIFT,
    S_MIX,
    S_ARK,
    S_DONE
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by the small constants used in (Inv)MixColumns.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (m)
      4'd2:    return x2;
      4'd3:    return x2 ^ b;
      4'd9:    return x8 ^ b;
      4'd11:   return x8 ^ x2 ^ b;
      4'd13:   return x8 ^ x4 ^ b;
      4'd14:   return x8 ^ x4 ^ x2;
      default: return b;
    endcase
  endfunction

  // Row r rotates left by r; byte index is 4*col + row.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col,
  input  logic             inv,
  output logic [COL_W-1:0] result_c
);

  logic [7:0] a [4];
  logic [3:0] m [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = col[31-8*r -: 8];
    end
    if (inv) begin
      m[0] = 4'd14; m[1] = 4'd11; m[2] = 4'd13; m[3] = 4'd9;
    end else begin
      m[0] = 4'd2;  m[1] = 4'd3;  m[2] = 4'd1;  m[3] = 4'd1;
    end
  end

  // Circulant matrix: output row r uses coefficient m[k] on input row r+k.
  always_comb begin
    result_c = '0;
    for (int r = 0; r < 4; r++) begin
      result_c[31-8*r -: 8] = gf_mul(a[r], m[0]) ^ gf_mul(a[(r+1)%4], m[1]) ^
                              gf_mul(a[(r+2)%4], m[2]) ^ gf_mul(a[(r+3)%4], m[3]);
    end
  end

endmodule

// File: rtl/aes_round_engine.sv
// Multi-round AES linear layer (AddRoundKey, (Inv)ShiftRows, (Inv)MixColumns),
// one operation per clock, with round-key fetch by index.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS    = 10,
  parameter bit          LAST_SKIP_MIX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [BLK_W-1:0]  data_in,
  output logic              key_req,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [BLK_W-1:0]  rkey,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  data_out,
  output logic [KIDX_W-1:0] round_cnt,
  output logic              busy
);

  localparam logic [KIDX_W-1:0] LAST = KIDX_W'(NUM_ROUNDS);

  fsm_e              state_q, state_d;
  logic [BLK_W-1:0]  st_q, st_d;
  logic              mode_q, mode_d;
  logic [BLK_W-1:0]  dout_d;
  logic [KIDX_W-1:0] round_d, kidx_d;
  logic              key_req_d, busy_d, out_valid_d;
  logic [BLK_W-1:0]  mixed_c;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col      (st_q[127-32*c -: 32]),
      .inv      (mode_q),
      .result_c (mixed_c[127-32*c -: 32])
    );
  end

  assign in_ready = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      st_q      <= '0;
      mode_q    <= 1'b0;
      data_out  <= '0;
      round_cnt <= '0;
      key_idx   <= '0;
      key_req   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      mode_q    <= mode_d;
      data_out  <= dout_d;
      round_cnt <= round_d;
      key_idx   <= kidx_d;
      key_req   <= key_req_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
    end
  end

  // Encrypt: ARK, then per round SHIFT/MIX/ARK. Decrypt walks rounds N..1 as MIX/SHIFT/ARK.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    mode_d  = mode_q;
    dout_d  = data_out;
    round_d = round_cnt;
    kidx_d  = key_idx;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_INIT_ARK;
          st_d    = data_in;
          mode_d  = mode;
          round_d = '0;
          kidx_d  = mode ? LAST : '0;
        end
      end
      S_INIT_ARK: begin
        st_d    = st_q ^ rkey;
        round_d = mode_q ? LAST : KIDX_W'(1);
        if (!mode_q || LAST_SKIP_MIX) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_MIX;
        end
      end
      S_SHIFT: begin
        if (mode_q) begin
          st_d    = inv_shift_rows(st_q);
          state_d = S_ARK;
          kidx_d  = round_cnt - KIDX_W'(1);
        end else begin
          st_d = shift_rows(st_q);
          if (LAST_SKIP_MIX && (round_cnt == LAST)) begin
            state_d = S_ARK;
            kidx_d  = round_cnt;
          end else begin
            state_d = S_MIX;
          end
        end
      end
      S_MIX: begin
        st_d = mixed_c;
        if (mode_q) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_ARK;
          kidx_d  = round_cnt;
        end
      end
      S_ARK: begin
        st_d = st_q ^ rkey;
        if (mode_q ? (round_cnt == KIDX_W'(1)) : (round_cnt == LAST)) begin
          state_d = S_DONE;
          dout_d  = st_q ^ rkey;
        end else if (mode_q) begin
          state_d = S_MIX;
          round_d = round_cnt - KIDX_W'(1);
        end else begin
          state_d = S_SHIFT;
          round_d = round_cnt + KIDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    key_req_d   = (state_d == S_INIT_ARK) || (state_d == S_ARK);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine across three parameter sets.
module tb_aes_round_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        in_valid_v;
  logic [2:0]        in_ready_v, out_valid_v, key_req_v, busy_v;
  logic              mode, out_ready, use_key;
  logic [127:0]      din;
  logic [2:0][127:0] dout_v, rkey_v;
  logic [2:0][3:0]   key_idx_v, round_v;

  int checks = 0;
  int passed = 0;
  int keys[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] kbyte(input logic [3:0] i);
    return 8'({4'h0, i} * 8'h1d) ^ 8'h5b;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rkey_v[k] = use_key ? {16{kbyte(key_idx_v[k])}} : '0;
    end
  end

  aes_round_engine #(.NUM_ROUNDS(1), .LAST_SKIP_MIX(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .mode(mode), .data_in(din), .key_req(key_req_v[0]), .key_idx(key_idx_v[0]),
    .rkey(rkey_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .data_out(dout_v[0]), .round_cnt(round_v[0]), .busy(busy_v[0]));

  aes_round_engine #(.NUM_ROUNDS(1), .LAST_SKIP_MIX(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .mode(mode), .data_in(din), .key_req(key_req_v[1]), .key_idx(key_idx_v[1]),
    .rkey(rkey_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .data_out(dout_v[1]), .round_cnt(round_v[1]), .busy(busy_v[1]));

  aes_round_engine #(.NUM_ROUNDS(10), .LAST_SKIP_MIX(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .mode(mode), .data_in(din), .key_req(key_req_v[2]), .key_idx(key_idx_v[2]),
    .rkey(rkey_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .data_out(dout_v[2]), .round_cnt(round_v[2]), .busy(busy_v[2]));

  // Accept one block on instance s, wait for out_valid, optionally consume it.
  task automatic run_block(input int s, input logic m, input logic [127:0] d,
                           input int exp_lat, input logic [3:0] exp_rnd,
                           input string name, output logic [127:0] res);
    int cyc;
    keys.delete();
    cyc = 0;
    while (in_ready_v[s] !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    din = d; mode = m; in_valid_v[s] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[s] = 1'b0;
    checks++;
    if (in_ready_v[s] !== 1'b0 || busy_v[s] !== 1'b1)
      $display("FAIL %s accept: in_ready=%b busy=%b required 0/1", name, in_ready_v[s], busy_v[s]);
    else passed++;
    cyc = 0;
    while (out_valid_v[s] !== 1'b1 && cyc < 100) begin
      if (key_req_v[s] === 1'b1) keys.push_back(int'(key_idx_v[s]));
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (out_valid_v[s] !== 1'b1 || cyc != exp_lat)
      $display("FAIL %s latency: out_valid=%b after %0d cycles required %0d", name, out_valid_v[s], cyc, exp_lat);
    else passed++;
    checks++;
    if (round_v[s] !== exp_rnd || key_req_v[s] !== 1'b0)
      $display("FAIL %s done_state: round_cnt=%0d key_req=%b required %0d/0", name, round_v[s], key_req_v[s], exp_rnd);
    else passed++;
    res = dout_v[s];
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready_v[s] !== 1'b1 || out_valid_v[s] !== 1'b0)
        $display("FAIL %s release: in_ready=%b out_valid=%b required 1/0", name, in_ready_v[s], out_valid_v[s]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready_v !== 3'b111 || out_valid_v !== 3'b000 || busy_v !== 3'b000 || key_req_v !== 3'b000)
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b key_req=%b required 111/000/000/000",
               in_ready_v, out_valid_v, busy_v, key_req_v);
    else passed++;
    checks++;
    if (dout_v[2] !== '0 || round_v[2] !== 4'd0 || key_idx_v[2] !== 4'd0)
      $display("FAIL reset_regs: data_out=%h round_cnt=%0d key_idx=%0d required 0", dout_v[2], round_v[2], key_idx_v[2]);
    else passed++;
  endtask

  task automatic test_enc_mix();
    logic [127:0] res;
    use_key = 1'b0;
    run_block(0, 1'b0, {4{32'hdb135345}}, 4, 4'd1, "enc_mix", res);
    checks++;
    if (res !== {4{32'h8e4da1bc}})
      $display("FAIL enc_mix data: got %h required %h", res, {4{32'h8e4da1bc}});
    else passed++;
  endtask

  task automatic test_enc_skip();
    logic [127:0] res;
    use_key = 1'b0;
    run_block(1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 3, 4'd1, "enc_skip", res);
    checks++;
    if (res !== 128'h00050a0f04090e03080d02070c01060b)
      $display("FAIL enc_skip data: got %h required %h", res, 128'h00050a0f04090e03080d02070c01060b);
    else passed++;
  endtask

  task automatic test_roundtrip(input logic [127:0] x, input string name);
    logic [127:0] ct, pt;
    bit ok;
    use_key = 1'b1;
    run_block(2, 1'b0, x, 30, 4'd10, {name, "_enc"}, ct);
    ok = (keys.size() == 11);
    for (int i = 0; i < keys.size() && i < 11; i++) if (keys[i] != i) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL %s_enc key_seq: got %0d indices (first %0d) required 0..10", name, keys.size(),
                      keys.size() > 0 ? keys[0] : -1);
    else passed++;
    run_block(2, 1'b1, ct, 30, 4'd1, {name, "_dec"}, pt);
    ok = (keys.size() == 11);
    for (int i = 0; i < keys.size() && i < 11; i++) if (keys[i] != 10 - i) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL %s_dec key_seq: got %0d indices (first %0d) required 10..0", name, keys.size(),
                      keys.size() > 0 ? keys[0] : -1);
    else passed++;
    checks++;
    if (pt !== x) $display("FAIL %s roundtrip: got %h required %h", name, pt, x);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int cyc;
    use_key = 1'b0;
    out_ready = 1'b0;
    run_block(0, 1'b0, {4{32'hdb135345}}, 4, 4'd1, "bp_first", res);
    din = {4{32'hf20a225c}}; mode = 1'b0; in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_v[0] !== 1'b1 || dout_v[0] !== {4{32'h8e4da1bc}} || in_ready_v[0] !== 1'b0)
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b data=%h required 1/0/%h",
                 i, out_valid_v[0], in_ready_v[0], dout_v[0], {4{32'h8e4da1bc}});
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready_v[0], out_valid_v[0]);
    else passed++;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b1) $display("FAIL bp_reaccept: busy=%b required 1", busy_v[0]);
    else passed++;
    cyc = 0;
    while (out_valid_v[0] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != 4 || dout_v[0] !== {4{32'h9fdc589d}})
      $display("FAIL bp_second: latency %0d data %h required 4 / %h", cyc, dout_v[0], {4{32'h9fdc589d}});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    use_key = 1'b1;
    din = 128'h00112233445566778899aabbccddeeff; mode = 1'b0; in_valid_v[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[2] = 1'b0;
    cyc = 0;
    while (round_v[2] !== 4'd3 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (round_v[2] !== 4'd3) $display("FAIL rstmid_reach: round_cnt=%0d required 3", round_v[2]);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid_v[2] !== 1'b0 || key_req_v[2] !== 1'b0 || busy_v[2] !== 1'b0 || in_ready_v[2] !== 1'b1 ||
        dout_v[2] !== '0 || round_v[2] !== 4'd0 || key_idx_v[2] !== 4'd0)
      $display("FAIL rstmid_clear: out_valid=%b key_req=%b busy=%b in_ready=%b data=%h round=%0d key_idx=%0d required 0/0/0/1/0/0/0",
               out_valid_v[2], key_req_v[2], busy_v[2], in_ready_v[2], dout_v[2], round_v[2], key_idx_v[2]);
    else passed++;
    test_roundtrip(128'h3243f6a8885a308d313198a2e0370734, "post_rst");
  endtask

  task automatic test_decrypt();
    logic [127:0] res;
    use_key = 1'b0;
    run_block(0, 1'b1, {4{32'h8e4da1bc}}, 4, 4'd1, "dec_mix", res);
    checks++;
    if (res !== {4{32'hdb135345}})
      $display("FAIL dec_mix data: got %h required %h", res, {4{32'hdb135345}});
    else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid_v = '0; mode = 1'b0; out_ready = 1'b1; use_key = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_enc_mix();
    test_enc_skip();
    test_roundtrip(128'h0123456789abcdeffedcba9876543210, "rt");
    test_backpressure();
    test_reset_mid();
    test_decrypt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
